bin_gray_arbiter: RTL and testbench



---
 rtl/bin_gray_arbiter.sv | 122 ++++++++++++
 tb/tb_bin_gray_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bin_gray_arbiter.sv
// bin_gray_arbiter: two-requester round-robin front end feeding one
// registered binary-to-Gray stage with a valid/ready output port.
// Optional feature macro: BIN_GRAY_ARB_PARITY_EN adds out_parity, the
// XOR-reduction of the held Gray word, registered alongside out_gray.
//
// Handshake semantics (all three ports): a transfer happens on a rising
// clock edge where valid and ready are both 1. Producers hold valid and
// data stable until ready is seen. Readies here are combinational from
// out_ready, a_valid and b_valid, and at most one input ready is high.
module bin_gray_arbiter #(
  parameter int Width = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [Width-1:0] a_bin,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [Width-1:0] b_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_gray,
`ifdef BIN_GRAY_ARB_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [Width-1:0]   gray_q, gray_d;
  logic               id_q, id_d;
  logic               last_id_q, last_id_d;
  logic               can_accept;
  logic               grant_valid;
  logic               grant_id;
  logic               accept;
  logic [Width-1:0]   granted_bin;
`ifdef BIN_GRAY_ARB_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // Arbitration, ready generation and next-state/result selection.
  always_comb begin
    state_d     = state_q;
    gray_d      = gray_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    granted_bin = a_bin;
    // The stage can take a new word when empty, or when the held result
    // leaves in this same cycle.
    can_accept  = (state_q == EMPTY) || out_ready;

    if (a_valid && b_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_id_q;
    end else if (a_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (b_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end

    granted_bin = grant_id ? b_bin : a_bin;
    accept      = can_accept && grant_valid;

    if (accept) begin
      state_d   = FULL;
      gray_d    = granted_bin ^ (granted_bin >> 1);
      id_d      = grant_id;
      last_id_d = grant_id;
    end else if (state_q == FULL && out_ready) begin
      state_d   = EMPTY;
    end
  end

`ifdef BIN_GRAY_ARB_PARITY_EN
  // Parity is computed from the word being loaded so it tracks out_gray.
  always_comb begin
    parity_d = parity_q;
    if (accept) parity_d = ^gray_d;
  end

  // Parity register, cleared with the rest of the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end

  assign out_parity = parity_q;
`endif

  // State and result registers; last_id resets to B so A wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      gray_q    <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      gray_q    <= gray_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
    end
  end

  assign a_ready   = accept && !grant_id;
  assign b_ready   = accept && grant_id;
  assign out_valid = (state_q == FULL);
  assign out_gray  = gray_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_bin_gray_arbiter.sv
// Testbench for bin_gray_arbiter: directed vector table plus hand-written
// sequences for backpressure-free reset and mid-transfer reset.
module tb_bin_gray_arbiter;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         a_valid, b_valid, out_ready;
  logic [W-1:0] a_bin, b_bin;
  logic         a_ready, b_ready, out_valid, out_id;
  logic [W-1:0] out_gray;
`ifdef BIN_GRAY_ARB_PARITY_EN
  logic         out_parity;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         av;
    logic [W-1:0] ab;
    logic         bv;
    logic [W-1:0] bb;
    logic         ordy;
    logic         ear;
    logic         ebr;
    logic         eov;
    logic [W-1:0] eg;
    logic         eid;
  } vec_t;

  vec_t vecs[$];

  bin_gray_arbiter #(.Width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_bin     (a_bin),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_bin     (b_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
`ifdef BIN_GRAY_ARB_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_id    (out_id)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic eov, input logic [W-1:0] eg,
                           input logic eid);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
    if (eov) begin
      chk({tag, ".out_gray"}, 32'(out_gray), 32'(eg));
      chk({tag, ".out_id"}, 32'(out_id), 32'(eid));
`ifdef BIN_GRAY_ARB_PARITY_EN
      chk({tag, ".out_parity"}, 32'(out_parity), 32'(^eg));
`endif
    end
  endtask

  task automatic drive(input logic av, input logic [W-1:0] ab, input logic bv,
                       input logic [W-1:0] bb, input logic ordy);
    a_valid   = av;
    a_bin     = ab;
    b_valid   = bv;
    b_bin     = bb;
    out_ready = ordy;
  endtask

  // Apply one vector: readies checked mid-cycle, outputs after the edge.
  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(v.av, v.ab, v.bv, v.bb, v.ordy);
    #1;
    chk({tag, ".a_ready"}, 32'(a_ready), 32'(v.ear));
    chk({tag, ".b_ready"}, 32'(b_ready), 32'(v.ebr));
    @(posedge clk);
    #1;
    check_out(tag, v.eov, v.eg, v.eid);
  endtask

  task automatic add(input logic av, input logic [W-1:0] ab, input logic bv,
                     input logic [W-1:0] bb, input logic ordy, input logic ear,
                     input logic ebr, input logic eov, input logic [W-1:0] eg,
                     input logic eid);
    vec_t v;
    v.av = av; v.ab = ab; v.bv = bv; v.bb = bb; v.ordy = ordy;
    v.ear = ear; v.ebr = ebr; v.eov = eov; v.eg = eg; v.eid = eid;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] sweep_exp [8];
    sweep_exp = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    //            av ab      bv bb      rdy ar br ov  gray    id
    // First accept right after reset.
    add(1, 3'b011, 0, 3'b000, 1,  1, 0, 1, 3'b010, 0);
    // B alone, leaves last_id = B so the next contention goes to A.
    add(0, 3'b000, 1, 3'b001, 1,  0, 1, 1, 3'b001, 1);
    // Continuous contention alternates A, B, A, B at one result per cycle.
    add(1, 3'b100, 1, 3'b101, 1,  1, 0, 1, 3'b110, 0);
    add(1, 3'b100, 1, 3'b101, 1,  0, 1, 1, 3'b111, 1);
    add(1, 3'b100, 1, 3'b101, 1,  1, 0, 1, 3'b110, 0);
    add(1, 3'b100, 1, 3'b101, 1,  0, 1, 1, 3'b111, 1);
    // Exhaustive sweep through A.
    for (int i = 0; i < 8; i++)
      add(1, W'(i), 0, 3'b000, 1,  1, 0, 1, sweep_exp[i], 0);
    // Backpressure: B accepted, then 3 stalled cycles with A pending.
    add(0, 3'b000, 1, 3'b111, 1,  0, 1, 1, 3'b100, 1);
    add(1, 3'b010, 0, 3'b000, 0,  0, 0, 1, 3'b100, 1);
    add(1, 3'b010, 0, 3'b000, 0,  0, 0, 1, 3'b100, 1);
    add(1, 3'b010, 0, 3'b000, 0,  0, 0, 1, 3'b100, 1);
    add(1, 3'b010, 0, 3'b000, 1,  1, 0, 1, 3'b011, 0);
    // Drain with no requests: back to EMPTY.
    add(0, 3'b000, 0, 3'b000, 1,  0, 0, 0, 3'b000, 0);
    // Idle while empty and consumer stalled: stays empty, no readies.
    add(0, 3'b000, 0, 3'b000, 0,  0, 0, 0, 3'b000, 0);
    // Accept into EMPTY even with out_ready low, then hold.
    add(0, 3'b000, 1, 3'b110, 0,  0, 1, 1, 3'b101, 1);
    add(1, 3'b001, 1, 3'b010, 0,  0, 0, 1, 3'b101, 1);

    // Reset block
    drive(0, '0, 0, '0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, '0, 1'b0);
    chk("reset.out_gray", 32'(out_gray), 32'd0);
    chk("reset.out_id", 32'(out_id), 32'd0);
    chk("reset.a_ready_idle", 32'(a_ready), 32'd0);
    chk("reset.b_ready_idle", 32'(b_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Mid-transfer reset: load 3'b110 (A = 3'b100), stall, then reset.
    @(negedge clk);
    drive(1, 3'b100, 0, '0, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    drive(0, '0, 0, '0, 0);
    #1;
    check_out("hold_before_rst", 1'b1, 3'b110, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    chk("async_rst.out_gray", 32'(out_gray), 32'd0);
    chk("async_rst.out_id", 32'(out_id), 32'd0);
`ifdef BIN_GRAY_ARB_PARITY_EN
    chk("async_rst.out_parity", 32'(out_parity), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 3'b011, 1, 3'b101, 1);
    #1;
    chk("post_rst.a_ready", 32'(a_ready), 32'd1);
    chk("post_rst.b_ready", 32'(b_ready), 32'd0);
    @(posedge clk);
    #1;
    check_out("post_rst", 1'b1, 3'b010, 1'b0);
    @(negedge clk);
    drive(0, '0, 0, '0, 1);
    @(posedge clk);
    #1;
    check_out("final_drain", 1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
